pword_sender: RTL and testbench
===============================

Name: pword_sender

Overview:
- User-side transmitter for the access login interface.
- Turns a debounced "enter digit" button and the 4-bit digit switches into clean, spaced, single-cycle `pword`/`pword_enter` strobes.
- Counts digits, then watches `pass_green` to report success or failure.
- Issues a one-cycle `abort` so the top level can resynchronise the access FSM after a failed or timed-out entry.

Parameters:
- DIGITS, 4, number of digits per login attempt (1..7).
- GAP, 2, minimum idle cycles after each `pword_enter` pulse before the next press is accepted.
- TIMEOUT, 1000, cycles allowed between accepted digits before the attempt is aborted.
- RESP_WAIT, 4, cycles to wait for `pass_green` after the last digit.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- digit_in  in  4  digit switch value, sampled on an accepted press.
- digit_btn  in  1  debounced enter button, active-high level.
- pass_green  in  1  login-granted indication from the access block.
- pword  out  4  digit presented to the access block.
- pword_enter  out  1  one-cycle strobe qualifying `pword`.
- digit_count  out  3  digits sent in the current attempt.
- busy  out  1  high while an attempt is in progress (first digit through result).
- login_ok  out  1  level; high while logged in.
- login_fail  out  1  one-cycle pulse on a rejected attempt.
- timeout_flag  out  1  one-cycle pulse on an inter-digit timeout.
- abort  out  1  one-cycle pulse; the top level folds it into the access block's reset.

Behaviour:
- Reset (RST=1 at an edge) drives:
  - state IDLE
  - `pword`=0, `pword_enter`=0, `digit_count`=0
  - `busy`=0, `login_ok`=0, `login_fail`=0, `timeout_flag`=0, `abort`=0
  - timers=0, `btn_q`=0
- Reset mid-attempt discards everything; no `abort` pulse is produced.
- Press detection: `btn_q` registers `digit_btn`. A press is `digit_btn & ~btn_q` (rising edge only); holding the button produces one press.
- States: IDLE, SEND, GAP, WAIT_DIGIT, CHECK, LOGGED_IN, FAIL, TMO.
- IDLE: on a press, `pword`<=`digit_in`, `pword_enter`<=1, `busy`<=1, go to SEND. `pword_enter` is high in the cycle after the press edge.
- SEND (1 cycle):
  - `pword_enter`<=0; `digit_count` increments.
  - If the new count equals DIGITS, go to CHECK with the response timer cleared.
  - Otherwise go to GAP with the gap timer cleared.
- GAP: presses are ignored. After GAP cycles, go to WAIT_DIGIT with the timeout timer cleared.
- WAIT_DIGIT:
  - On a press, same action as IDLE and go to SEND.
  - If the timer reaches TIMEOUT-1 with no press, go to TMO.
  - Timeout has priority over a press in the same cycle.
- CHECK:
  - If `pass_green`=1 in any of RESP_WAIT cycles, go to LOGGED_IN.
  - If not seen by the end of the window, go to FAIL.
- LOGGED_IN:
  - `login_ok`=1, `busy`=0; presses are ignored.
  - When `pass_green` falls, `login_ok`<=0 and go to IDLE.
- FAIL (1 cycle): `login_fail`=1, `abort`=1, `digit_count`<=0, `busy`<=0, then IDLE.
- TMO (1 cycle): `timeout_flag`=1, `abort`=1, `digit_count`<=0, `busy`<=0, then IDLE.
- `pword` holds its last value outside SEND and is only valid when `pword_enter`=1.
- `pword_enter` is never high in two consecutive cycles. Minimum spacing between strobes is GAP+2 cycles.
- Timer widths are sized by `$clog2` of the largest limit. No counter wraps; each saturates at its terminal value before the state exits.

Decomposition:
- Shared package holds:
  - state encodings (3-bit localparams)
  - DIGIT_W=4
  - default DIGITS/GAP/TIMEOUT/RESP_WAIT
  - the same package is reused by the access block.
- One natural sub-module: `pulse_edge`, a registered rising-edge detector with a synchronous reset, reusable for the other player buttons.

Test Plan:
- Reset, then presses with digits 3,1,5,3, each 5 cycles apart, with `pass_green` modelled 2 cycles after the 4th strobe → four single-cycle `pword_enter` pulses carrying 3,1,5,3; `digit_count` runs 1..4; `login_ok`=1 from 1 cycle after `pass_green`.
- Digits 3,1,5,4 with no `pass_green` → after 4 RESP_WAIT cycles, `login_fail`=1 and `abort`=1 for exactly 1 cycle; `digit_count`=0; IDLE.
- One digit, then no press for 1000 cycles → `timeout_flag` and `abort` pulse once; `digit_count` returns to 0.
- `digit_btn` held high for 50 cycles, and a second press 1 cycle after the first strobe (inside GAP) → exactly one `pword_enter`.
- RST asserted after 2 digits → next edge all outputs 0, `digit_count`=0, no `abort`; a fresh 4-digit entry then succeeds.
- While LOGGED_IN, pulse `digit_btn` → no strobe; drop `pass_green` → `login_ok`=0 next cycle, state IDLE.

Source files
------------

// File: rtl/pword_sender_pkg.sv
// ---------------------------------------------------------------------------
// pword_sender_pkg
// Shared definitions for the login path: the user-side sender (pword_sender)
// and the access block that receives its pword/pword_enter strobes.
//   - state_e      : 3-bit state encoding of the sender FSM
//   - DIGIT_W      : width of one password digit
//   - DEF_*        : default attempt length and timing limits
//   - max3()       : helper used to size the shared timer
// ---------------------------------------------------------------------------
package pword_sender_pkg;

  localparam int DIGIT_W = 4;

  // Default attempt shape and timing, in clock cycles.
  localparam int DEF_DIGITS    = 4;
  localparam int DEF_GAP       = 2;
  localparam int DEF_TIMEOUT   = 1000;
  localparam int DEF_RESP_WAIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND       = 3'd1,
    ST_GAP        = 3'd2,
    ST_WAIT_DIGIT = 3'd3,
    ST_CHECK      = 3'd4,
    ST_LOGGED_IN  = 3'd5,
    ST_FAIL       = 3'd6,
    ST_TMO        = 3'd7
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pword_sender_pulse_edge.sv
// ---------------------------------------------------------------------------
// pulse_edge
// Registered rising-edge detector with synchronous active-high reset.
// The level is registered once; rise is high for exactly the cycle in which
// the level is 1 and the registered copy is still 0, so a held level gives a
// single rise. Reusable for any already-debounced player button.
// Ports:
//   CLK   in  clock
//   RST   in  synchronous active-high reset (clears the registered copy)
//   level in  debounced level input
//   rise  out one-cycle rising-edge indication (combinational from level)
// ---------------------------------------------------------------------------
module pulse_edge (
  input  logic CLK,
  input  logic RST,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge CLK) begin
    if (RST) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/pword_sender.sv
// ---------------------------------------------------------------------------
// pword_sender
// User-side transmitter for the access login interface. Each accepted press
// of digit_btn emits one single-cycle pword_enter strobe carrying digit_in,
// with at least GAP+2 cycles between strobes. After DIGITS digits it watches
// pass_green for RESP_WAIT cycles and reports login_ok or login_fail. Too
// long a pause between digits gives timeout_flag. Failed and timed-out
// attempts also pulse abort so the top level can reset the access block.
//
// Strobe interface: pword_enter is a valid-only strobe with no ready; the
// receiver must accept pword in the one cycle pword_enter is high. pword is
// meaningful only in that cycle and otherwise holds its last value.
//
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   synchronous active-high reset
//   digit_in     in   digit switches, captured on an accepted press
//   digit_btn    in   debounced enter button level
//   pass_green   in   login granted from the access block
//   pword        out  digit presented to the access block
//   pword_enter  out  one-cycle strobe qualifying pword
//   digit_count  out  digits sent in the current attempt
//   busy         out  attempt in progress (first digit through result)
//   login_ok     out  level, high while logged in
//   login_fail   out  one-cycle pulse on a rejected attempt
//   timeout_flag out  one-cycle pulse on an inter-digit timeout
//   abort        out  one-cycle pulse after a failed or timed-out attempt
//   state_dbg    out  current FSM state (state_e encoding)
// ---------------------------------------------------------------------------
module pword_sender
  import pword_sender_pkg::*;
#(
  parameter int DIGITS    = DEF_DIGITS,    // 1..7
  parameter int GAP       = DEF_GAP,       // >= 1
  parameter int TIMEOUT   = DEF_TIMEOUT,   // >= 1
  parameter int RESP_WAIT = DEF_RESP_WAIT  // >= 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_btn,
  input  logic               pass_green,
  output logic [DIGIT_W-1:0] pword,
  output logic               pword_enter,
  output logic [2:0]         digit_count,
  output logic               busy,
  output logic               login_ok,
  output logic               login_fail,
  output logic               timeout_flag,
  output logic               abort,
  output logic [2:0]         state_dbg
);

  // One timer is shared by GAP, WAIT_DIGIT and CHECK; it only ever counts
  // up to (limit-1) of the state it serves, so it never wraps.
  localparam int TMAX = max3(GAP, TIMEOUT, RESP_WAIT);
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] RESP_LAST = TW'(RESP_WAIT - 1);
  localparam logic [2:0]    DIGITS_C  = 3'(DIGITS);

  state_e        state;
  logic [TW-1:0] timer;
  logic          press;
  logic [2:0]    cnt_next;

  pulse_edge u_btn_edge (
    .CLK   (CLK),
    .RST   (RST),
    .level (digit_btn),
    .rise  (press)
  );

  assign cnt_next  = digit_count + 3'd1;
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      timer        <= '0;
      pword        <= '0;
      pword_enter  <= 1'b0;
      digit_count  <= 3'd0;
      busy         <= 1'b0;
      login_ok     <= 1'b0;
      login_fail   <= 1'b0;
      timeout_flag <= 1'b0;
      abort        <= 1'b0;
    end else begin
      // Pulse outputs default low; they are set only on entry to the state
      // that owns them, which makes each exactly one cycle long.
      pword_enter  <= 1'b0;
      login_fail   <= 1'b0;
      timeout_flag <= 1'b0;
      abort        <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (press) begin
            pword       <= digit_in;
            pword_enter <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_SEND;
          end
        end

        ST_SEND: begin
          digit_count <= cnt_next;
          timer       <= '0;
          if (cnt_next == DIGITS_C) state <= ST_CHECK;
          else                      state <= ST_GAP;
        end

        // Presses are not acted on here, but the edge detector keeps
        // tracking the button, so a press held through GAP is not replayed.
        ST_GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            state <= ST_WAIT_DIGIT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Timeout is tested first so it wins over a press in the same cycle.
        ST_WAIT_DIGIT: begin
          if (timer == TMO_LAST) begin
            timeout_flag <= 1'b1;
            abort        <= 1'b1;
            digit_count  <= 3'd0;
            busy         <= 1'b0;
            state        <= ST_TMO;
          end else if (press) begin
            pword       <= digit_in;
            pword_enter <= 1'b1;
            state       <= ST_SEND;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_CHECK: begin
          if (pass_green) begin
            login_ok <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_LOGGED_IN;
          end else if (timer == RESP_LAST) begin
            login_fail  <= 1'b1;
            abort       <= 1'b1;
            digit_count <= 3'd0;
            busy        <= 1'b0;
            state       <= ST_FAIL;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Digit count is cleared on logout so the next attempt starts at 0.
        ST_LOGGED_IN: begin
          if (!pass_green) begin
            login_ok    <= 1'b0;
            digit_count <= 3'd0;
            state       <= ST_IDLE;
          end
        end

        ST_FAIL: state <= ST_IDLE;
        ST_TMO:  state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pword_sender.sv
// ---------------------------------------------------------------------------
// tb_pword_sender
// Self-checking bench for pword_sender with default parameters.
// Expected strobe digits are queued when a press is driven and compared
// against pword whenever pword_enter is seen.
// ---------------------------------------------------------------------------
module tb_pword_sender;
  import pword_sender_pkg::*;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] digit_in = '0;
  logic       digit_btn = 1'b0;
  logic       pass_green = 1'b0;

  logic [3:0] pword;
  logic       pword_enter;
  logic [2:0] digit_count;
  logic       busy, login_ok, login_fail, timeout_flag, abort;
  logic [2:0] state_dbg;

  always #5 CLK = ~CLK;

  pword_sender dut (
    .CLK          (CLK),
    .RST          (RST),
    .digit_in     (digit_in),
    .digit_btn    (digit_btn),
    .pass_green   (pass_green),
    .pword        (pword),
    .pword_enter  (pword_enter),
    .digit_count  (digit_count),
    .busy         (busy),
    .login_ok     (login_ok),
    .login_fail   (login_fail),
    .timeout_flag (timeout_flag),
    .abort        (abort),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int strobe_cnt = 0;
  int abort_cnt  = 0;
  logic prev_enter = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Strobe monitor: compare every strobe against the queue head.
  always @(negedge CLK) begin
    if (pword_enter) begin
      strobe_cnt++;
      check_eq("no_back_to_back", 32'(prev_enter), 32'd0);
      check_eq("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("pword", 32'(pword), 32'(exp_q.pop_front()));
    end
    if (abort) abort_cnt++;
    prev_enter = pword_enter;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One-cycle press; ends one cycle after the strobe and checks the count.
  task automatic press(input logic [3:0] d, input int exp_cnt);
    @(posedge CLK); #1;
    digit_in  = d;
    digit_btn = 1'b1;
    exp_q.push_back(d);
    @(posedge CLK); #1;
    digit_btn = 1'b0;
    @(posedge CLK); #1;
    check_eq("digit_count", 32'(digit_count), 32'(exp_cnt));
    check_eq("busy_during", 32'(busy), 32'd1);
  endtask

  task automatic check_all_clear(input string tag);
    check_eq({tag, "_pword"},   32'(pword), 32'd0);
    check_eq({tag, "_enter"},   32'(pword_enter), 32'd0);
    check_eq({tag, "_count"},   32'(digit_count), 32'd0);
    check_eq({tag, "_busy"},    32'(busy), 32'd0);
    check_eq({tag, "_ok"},      32'(login_ok), 32'd0);
    check_eq({tag, "_fail"},    32'(login_fail), 32'd0);
    check_eq({tag, "_tmo"},     32'(timeout_flag), 32'd0);
    check_eq({tag, "_abort"},   32'(abort), 32'd0);
    check_eq({tag, "_state"},   32'(state_dbg), 32'(ST_IDLE));
  endtask

  // Four digits spaced 5 cycles apart, then pass_green two cycles after the
  // last strobe; checks login_ok appears one cycle later.
  task automatic login_seq(input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3);
    press(d0, 1); tick(2);
    press(d1, 2); tick(2);
    press(d2, 3); tick(2);
    press(d3, 4);
    @(posedge CLK); #1;
    pass_green = 1'b1;
    check_eq("ok_not_yet", 32'(login_ok), 32'd0);
    check_eq("check_state", 32'(state_dbg), 32'(ST_CHECK));
    @(posedge CLK); #1;
    check_eq("login_ok", 32'(login_ok), 32'd1);
    check_eq("busy_after_ok", 32'(busy), 32'd0);
    check_eq("logged_state", 32'(state_dbg), 32'(ST_LOGGED_IN));
  endtask

  task automatic logout();
    @(posedge CLK); #1;
    pass_green = 1'b0;
    @(posedge CLK); #1;
    check_eq("logout_ok", 32'(login_ok), 32'd0);
    check_eq("logout_state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("logout_count", 32'(digit_count), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int n_fail, n_tmo_ab, n_tmo, first;

    // Reset state
    RST = 1'b1;
    tick(2);
    check_all_clear("reset");
    RST = 1'b0;
    tick($urandom_range(1, 4));

    // 1: successful login with 3,1,5,3; button pressed while logged in
    login_seq(4'd3, 4'd1, 4'd5, 4'd3);
    s0 = strobe_cnt;
    digit_in = 4'd9;
    digit_btn = 1'b1;
    tick(1);
    digit_btn = 1'b0;
    tick(3);
    check_eq("logged_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check_eq("logged_hold_ok", 32'(login_ok), 32'd1);
    logout();
    tick(2);

    // 2: rejected attempt 3,1,5,4
    press(4'd3, 1); tick(2);
    press(4'd1, 2); tick(2);
    press(4'd5, 3); tick(2);
    press(4'd4, 4);
    n_fail = 0; n_tmo_ab = 0; first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge CLK); #1;
      if (login_fail) begin
        n_fail++;
        if (first == 0) first = i;
      end
      if (abort) n_tmo_ab++;
    end
    check_eq("fail_pulses", 32'(n_fail), 32'd1);
    check_eq("fail_abort_pulses", 32'(n_tmo_ab), 32'd1);
    check_eq("fail_latency", 32'(first), 32'd4);
    check_eq("fail_count", 32'(digit_count), 32'd0);
    check_eq("fail_state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("fail_busy", 32'(busy), 32'd0);

    // 3: one digit then silence -> timeout
    press(4'd7, 1);
    n_tmo = 0; n_tmo_ab = 0; first = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge CLK); #1;
      if (timeout_flag) begin
        n_tmo++;
        if (first == 0) first = i;
      end
      if (abort) n_tmo_ab++;
    end
    check_eq("tmo_pulses", 32'(n_tmo), 32'd1);
    check_eq("tmo_abort_pulses", 32'(n_tmo_ab), 32'd1);
    check_eq("tmo_latency", 32'(first), 32'd1002);
    check_eq("tmo_count", 32'(digit_count), 32'd0);
    check_eq("tmo_state", 32'(state_dbg), 32'(ST_IDLE));

    // 4a: button held 50 cycles -> one strobe
    s0 = strobe_cnt;
    @(posedge CLK); #1;
    digit_in = 4'd6;
    digit_btn = 1'b1;
    exp_q.push_back(4'd6);
    tick(50);
    digit_btn = 1'b0;
    tick(1);
    check_eq("hold_one_strobe", 32'(strobe_cnt - s0), 32'd1);
    check_eq("hold_count", 32'(digit_count), 32'd1);

    // 4b: second press inside GAP is ignored
    s0 = strobe_cnt;
    press(4'd2, 2);
    digit_in = 4'd8;
    digit_btn = 1'b1;
    tick(1);
    digit_btn = 1'b0;
    tick(6);
    check_eq("gap_one_strobe", 32'(strobe_cnt - s0), 32'd1);
    check_eq("gap_count", 32'(digit_count), 32'd2);

    // 5: reset after 2 digits, then fresh successful entry
    RST = 1'b1;
    tick(1);
    check_all_clear("midreset");
    RST = 1'b0;
    tick(2);
    login_seq(4'd9, 4'd0, 4'd8, 4'd2);
    logout();
    tick(4);

    // Final report
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("abort_total", 32'(abort_cnt), 32'd2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
